// File: rtl/cfg_reg_bank_if.sv
// Register-bank access bus: controller-side requests, bank-side responses
// and the continuously exported configuration words.
interface cfg_reg_bank_if #(
  parameter int WIDTH   = 8,
  parameter int ADDR    = 4,
  parameter int NUM_EXP = 4
);
  logic                     WrEn;
  logic                     RdEn;
  logic [ADDR-1:0]          Address;
  logic [WIDTH-1:0]         WrData;
  logic [WIDTH-1:0]         WrMask;
  logic [WIDTH-1:0]         RdData;
  logic                     RdData_VLD;
  logic                     Err;
  logic                     Cfg_Chg;
  logic [NUM_EXP*WIDTH-1:0] REG_EXP;

  modport master (
    output WrEn, RdEn, Address, WrData, WrMask,
    input  RdData, RdData_VLD, Err, Cfg_Chg, REG_EXP
  );

  modport slave (
    input  WrEn, RdEn, Address, WrData, WrMask,
    output RdData, RdData_VLD, Err, Cfg_Chg, REG_EXP
  );
endinterface

// File: rtl/cfg_reg_bank.sv
// Parametrised configuration register bank: masked writes, read-only
// protection, error pulses and a change pulse on the exported registers.
module cfg_reg_bank #(
  parameter int                     WIDTH    = 8,
  parameter int                     DEPTH    = 16,
  parameter int                     ADDR     = 4,
  parameter int                     NUM_EXP  = 4,
  parameter logic [DEPTH*WIDTH-1:0] INIT_VEC =
      ((DEPTH*WIDTH)'(8'h81) << (2*WIDTH)) | ((DEPTH*WIDTH)'(8'h08) << (3*WIDTH)),
  parameter logic [DEPTH-1:0]       RO_MASK  = '0
) (
  input logic           CLK,
  input logic           RST,
  cfg_reg_bank_if.slave bus
);

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_vld;
  logic             r_err;
  logic             r_cfg_chg;

  logic             w_in_range;
  logic             w_ro;
  logic             w_exported;
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_cur;
  logic [WIDTH-1:0] w_new;

  // NOTE: every combinational output gets a default first so no path
  // through the block leaves it unassigned and infers a latch.
  always_comb begin
    w_in_range = 32'(bus.Address) < 32'(DEPTH);
    w_exported = 32'(bus.Address) < 32'(NUM_EXP);
    w_cur      = '0;
    w_ro       = 1'b0;
    if (w_in_range) begin
      w_cur = r_regs[bus.Address];
      w_ro  = RO_MASK[bus.Address];
    end
    w_new   = (w_cur & ~bus.WrMask) | (bus.WrData & bus.WrMask);
    w_wr_ok = w_in_range && !w_ro;
  end

  // NOTE: the storage array is reset too, because each register has a
  // defined power-up value that the exported configuration depends on.
  // NOTE: state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= INIT_VEC[i*WIDTH +: WIDTH];
      r_rd_data <= '0;
      r_rd_vld  <= 1'b0;
      r_err     <= 1'b0;
      r_cfg_chg <= 1'b0;
    end else begin
      r_rd_vld  <= 1'b0;
      r_err     <= 1'b0;
      r_cfg_chg <= 1'b0;
      if (bus.WrEn && bus.RdEn) begin
        r_err <= 1'b1;
      end else if (bus.WrEn) begin
        if (w_wr_ok) begin
          r_regs[bus.Address] <= w_new;
          r_cfg_chg           <= w_exported && (w_new != w_cur);
        end else begin
          r_err <= 1'b1;
        end
      end else if (bus.RdEn) begin
        // w_cur is already zero for out-of-range addresses
        r_rd_data <= w_cur;
        r_rd_vld  <= 1'b1;
        r_err     <= !w_in_range;
      end
    end
  end

  for (genvar g = 0; g < NUM_EXP; g++) begin : g_exp
    assign bus.REG_EXP[g*WIDTH +: WIDTH] = r_regs[g];
  end

  assign bus.RdData     = r_rd_data;
  assign bus.RdData_VLD = r_rd_vld;
  assign bus.Err        = r_err;
  assign bus.Cfg_Chg    = r_cfg_chg;

endmodule
